// File: rtl/prim_reg_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prim_reg_bus_pkg
// Brief    : Shared types, constants and decode helper for the register bus.
// Revision : 1.0
// ============================================================================
package prim_reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int c_ADDR_LSB = 2;

  // Error when misaligned, beyond the decoded register range, or a partial write.
  function automatic logic decode_err(input logic [31:0] addr,
                                      input logic [3:0]  be,
                                      input logic        write,
                                      input int unsigned num_regs);
    logic [31:0] idx;
    idx = addr >> c_ADDR_LSB;
    return (addr[1:0] != 2'b00) || (idx >= num_regs) ||
           (write && (be != 4'h0) && (be != 4'hF));
  endfunction

endpackage
`default_nettype wire

// File: rtl/prim_reg_addr_dec.sv
`default_nettype none
// ============================================================================
// Module   : prim_reg_addr_dec
// Brief    : Combinational word-index, one-hot select and access-error decode.
// Revision : 1.0
// ============================================================================
module prim_reg_addr_dec
  import prim_reg_bus_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 12,
  parameter int NUM_REGS = 8
) (
  input  logic [AW-1:0]          i_addr,
  input  logic [DW/8-1:0]        i_be,
  input  logic                   i_write,
  output logic [AW-c_ADDR_LSB-1:0] o_idx,
  output logic [NUM_REGS-1:0]    o_onehot,
  output logic                   o_err
);

  localparam int c_IW = AW - c_ADDR_LSB;

  assign o_idx = i_addr[AW-1:c_ADDR_LSB];
  assign o_err = decode_err(32'(i_addr), 4'(i_be), i_write, NUM_REGS);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_onehot
    assign o_onehot[i] = (o_idx == c_IW'(i));
  end

endmodule
`default_nettype wire

// File: rtl/prim_reg_bus_adapter.sv
`default_nettype none
// ============================================================================
// Module   : prim_reg_bus_adapter
// Brief    : Single-outstanding valid/ready bus to register-slice pulse adapter.
// Revision : 1.0
// ============================================================================
module prim_reg_bus_adapter
  import prim_reg_bus_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 12,
  parameter int NUM_REGS = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [AW-1:0]          req_addr_i,
  input  logic [DW-1:0]          req_wdata_i,
  input  logic [DW/8-1:0]        req_be_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DW-1:0]          rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic [NUM_REGS-1:0]    reg_we_o,
  output logic [NUM_REGS-1:0]    reg_re_o,
  output logic [DW-1:0]          reg_wd_o,
  input  logic [NUM_REGS*DW-1:0] reg_rdata_i
);

  localparam int c_IW = AW - c_ADDR_LSB;

  state_e                r_state;
  state_e                w_state_next;
  logic                  w_req_ready;
  logic                  w_rsp_valid;
  logic                  w_accept;

  logic [c_IW-1:0]       w_dec_idx;
  logic [NUM_REGS-1:0]   w_dec_onehot;
  logic                  w_dec_err;

  logic                  r_write;
  logic [c_IW-1:0]       r_idx;
  logic                  r_err;
  logic [NUM_REGS-1:0]   r_we;
  logic [NUM_REGS-1:0]   r_re;
  logic [DW-1:0]         r_wd;
  logic [DW-1:0]         r_rsp_rdata;
  logic                  r_rsp_error;
  logic [DW-1:0]         w_sel_rdata;

  // Decode straight off the request so the pulses can be registered into ACCESS.
  prim_reg_addr_dec #(
    .DW       (DW),
    .AW       (AW),
    .NUM_REGS (NUM_REGS)
  ) u_addr_dec (
    .i_addr   (req_addr_i),
    .i_be     (req_be_i),
    .i_write  (req_write_i),
    .o_idx    (w_dec_idx),
    .o_onehot (w_dec_onehot),
    .o_err    (w_dec_err)
  );

  assign w_accept = req_valid_i && w_req_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_valid_i) w_state_next = ACCESS;
      ACCESS:  w_state_next = RESP;
      RESP:    if (rsp_ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      IDLE:    w_req_ready = 1'b1;
      RESP:    w_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_idx == c_IW'(i)) w_sel_rdata = reg_rdata_i[i*DW +: DW];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_we        <= '0;
      r_re        <= '0;
      r_wd        <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_we <= '0;
      r_re <= '0;
      if (w_accept) begin
        r_write <= req_write_i;
        r_idx   <= w_dec_idx;
        r_err   <= w_dec_err;
        if (req_write_i && !w_dec_err && (req_be_i == '1)) begin
          r_we <= w_dec_onehot;
          r_wd <= req_wdata_i;
        end
        if (!req_write_i && !w_dec_err) r_re <= w_dec_onehot;
      end
      // Sampled while the read pulse is high, i.e. before any RC clear lands.
      if (r_state == ACCESS) begin
        r_rsp_error <= r_err;
        r_rsp_rdata <= (!r_write && !r_err) ? w_sel_rdata : '0;
      end
    end
  end

  assign req_ready_o = w_req_ready;
  assign rsp_valid_o = w_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_error_o = r_rsp_error;
  assign reg_we_o    = r_we;
  assign reg_re_o    = r_re;
  assign reg_wd_o    = r_wd;

endmodule
`default_nettype wire

// File: tb/tb_prim_reg_bus_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_reg_bus_adapter
// Brief    : Self-checking bench for prim_reg_bus_adapter against a txn model.
// Revision : 1.0
// ============================================================================
module tb_prim_reg_bus_adapter;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NR = 8;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [3:0]      req_be;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_error;
  logic [NR-1:0]   reg_we;
  logic [NR-1:0]   reg_re;
  logic [DW-1:0]   reg_wd;
  logic [NR*DW-1:0] reg_rdata;

  logic [31:0]     regs [NR];
  logic [31:0]     m_wd;
  int              n_checks;
  int              n_errors;

  prim_reg_bus_adapter #(
    .DW       (DW),
    .AW       (AW),
    .NUM_REGS (NR)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_error_o (rsp_error),
    .reg_we_o    (reg_we),
    .reg_re_o    (reg_re),
    .reg_wd_o    (reg_wd),
    .reg_rdata_i (reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NR; i++) reg_rdata[i*DW +: DW] = regs[i];
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int stall);
    int           idx;
    bit           err;
    logic [NR-1:0] e_we;
    logic [NR-1:0] e_re;
    logic [31:0]  e_rd;
    idx  = int'(addr) / 4;
    err  = (addr % 4 != 0) || (idx >= NR) || (wr && be != 4'h0 && be != 4'hF);
    e_we = '0;
    e_re = '0;
    e_rd = '0;
    if (!err && wr && be == 4'hF) begin
      e_we = NR'(1) << idx;
      m_wd = wd;
    end
    if (!err && !wr) begin
      e_re = NR'(1) << idx;
      e_rd = regs[idx];
    end

    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    check_value("ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
    @(negedge clk);
    check_value("access_we", reg_we, e_we);
    check_value("access_re", reg_re, e_re);
    check_value("access_wd", reg_wd, m_wd);
    check_value("access_ready", req_ready, 0);
    check_value("access_valid", rsp_valid, 0);
    @(negedge clk);
    check_value("resp_valid", rsp_valid, 1);
    check_value("resp_rdata", rsp_rdata, e_rd);
    check_value("resp_error", rsp_error, err);
    check_value("resp_pulse", {reg_we, reg_re}, 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      randomize_regs();
      @(negedge clk);
      check_value("stall_valid", rsp_valid, 1);
      check_value("stall_rdata", rsp_rdata, e_rd);
      check_value("stall_error", rsp_error, err);
      check_value("stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check_value("post_valid", rsp_valid, 0);
    check_value("post_ready", req_ready, 1);
    check_value("post_wd", reg_wd, m_wd);
  endtask

  initial begin
    int          accepts [4];
    int          acc_n;
    int          we_cnt;
    logic [AW-1:0] a;
    logic [3:0]  b;

    n_checks  = 0;
    n_errors  = 0;
    m_wd      = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    randomize_regs();
    #1;
    check_value("rst_ready", req_ready, 1);
    check_value("rst_valid", rsp_valid, 0);
    check_value("rst_rdata", rsp_rdata, 0);
    check_value("rst_error", rsp_error, 0);
    check_value("rst_pulses", {reg_we, reg_re}, 0);
    check_value("rst_wd", reg_wd, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 0);
    regs[3] = 32'h0000_00A5;
    do_txn(1'b0, 12'h00C, 32'h0, 4'hF, 0);
    do_txn(1'b0, 12'h020, 32'h0, 4'hF, 0);
    do_txn(1'b0, 12'h006, 32'h0, 4'hF, 0);
    do_txn(1'b1, 12'h010, 32'h12345678, 4'h3, 0);
    do_txn(1'b1, 12'h010, 32'h87654321, 4'h0, 0);
    do_txn(1'b0, 12'h01C, 32'h0, 4'h0, 5);

    // Reset while a write to reg 1 is in its pulse cycle.
    req_write = 1'b1;
    req_addr  = 12'h004;
    req_wdata = 32'hCAFEF00D;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_value("rstmid_we_before", reg_we, 8'b0000_0010);
    #1 rst_n = 1'b0;
    #1;
    check_value("rstmid_we_drop", reg_we, 0);
    check_value("rstmid_wd", reg_wd, 0);
    m_wd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_value("rstmid_valid", rsp_valid, 0);
    check_value("rstmid_ready", req_ready, 1);
    @(negedge clk);
    check_value("rstmid_valid2", rsp_valid, 0);

    // Back-to-back writes with the response side always ready.
    rsp_ready = 1'b1;
    req_write = 1'b1;
    req_be    = 4'hF;
    req_addr  = 12'h000;
    req_wdata = $urandom;
    req_valid = 1'b1;
    acc_n     = 0;
    we_cnt    = 0;
    for (int c = 0; c < 14; c++) begin
      bit acc;
      acc = req_valid && req_ready;
      if (acc) begin
        accepts[acc_n] = c;
        acc_n++;
      end
      check_value("tp_we_re_excl", (reg_we & reg_re) == 0 ? 1 : 0, 1);
      if (reg_we != 0) begin
        check_value("tp_we_onehot", reg_we, NR'(1) << we_cnt);
        we_cnt++;
      end
      @(posedge clk); #1;
      if (acc) begin
        m_wd = req_wdata;
        if (acc_n == 4) req_valid = 1'b0;
        else begin
          req_addr  = AW'(acc_n * 4);
          req_wdata = $urandom;
        end
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check_value("tp_accept_cnt", acc_n, 4);
    check_value("tp_we_cnt", we_cnt, 4);
    for (int k = 0; k < 4; k++) check_value("tp_accept_cycle", accepts[k], 3 * k);

    for (int t = 0; t < 40; t++) begin
      randomize_regs();
      case ($urandom_range(0, 3))
        0, 1:    a = AW'($urandom_range(0, NR - 1) * 4);
        2:       a = AW'($urandom_range(0, NR * 4 - 1)) | 12'h001;
        default: a = AW'($urandom_range(NR, 1023) * 4);
      endcase
      case ($urandom_range(0, 2))
        0:       b = 4'hF;
        1:       b = 4'h0;
        default: b = 4'($urandom);
      endcase
      do_txn(1'($urandom_range(0, 1)), a, $urandom, b, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
